// File: rtl/rvfi_compare_queue.sv
// rvfi_compare_queue: buffers DUT retirements from up to NRET channels and
// compares them in order against a single-stream reference model.
// Handshake: the reference side transfers on a clock edge where
// ref_valid_i && ref_ready_o; ref_ready_o depends only on registered state.
// Debug: the RUN/HALT state is visible on halted_o.
module rvfi_compare_queue #(
    parameter int NRET             = 2,
    parameter int DEPTH            = 8,
    parameter int XLEN             = 32,
    parameter int STOP_ON_MISMATCH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NRET-1:0]            dut_valid_i,
    input  logic [NRET*64-1:0]         dut_order_i,
    input  logic [NRET*XLEN-1:0]       dut_pc_i,
    input  logic [NRET*32-1:0]         dut_insn_i,
    input  logic [NRET-1:0]            dut_trap_i,
    input  logic [NRET*5-1:0]          dut_rd_addr_i,
    input  logic [NRET*XLEN-1:0]       dut_rd_wdata_i,
    input  logic                       ref_valid_i,
    output logic                       ref_ready_o,
    input  logic [63:0]                ref_order_i,
    input  logic [XLEN-1:0]            ref_pc_i,
    input  logic [31:0]                ref_insn_i,
    input  logic                       ref_trap_i,
    input  logic [4:0]                 ref_rd_addr_i,
    input  logic [XLEN-1:0]            ref_rd_wdata_i,
    input  logic                       flush_i,
    output logic                       cmp_valid_o,
    output logic                       mismatch_o,
    output logic [4:0]                 mismatch_mask_o,
    output logic [15:0]                mismatch_cnt_o,
    output logic [63:0]                first_mm_order_o,
    output logic                       overflow_o,
    output logic                       halted_o,
    output logic [$clog2(DEPTH):0]     occupancy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

    // Entry storage, one array per retirement field
    logic [63:0]     q_order  [DEPTH];
    logic [XLEN-1:0] q_pc     [DEPTH];
    logic [31:0]     q_insn   [DEPTH];
    logic            q_trap   [DEPTH];
    logic [4:0]      q_rd     [DEPTH];
    logic [XLEN-1:0] q_wdata  [DEPTH];

    state_e            state_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              cmp_valid_q, mismatch_q, overflow_q;
    logic [4:0]        mask_q;
    logic [15:0]       mm_cnt_q;
    logic [63:0]       first_mm_q;

    logic [OCC_W-1:0]  push_cnt;
    logic [PTR_W-1:0]  wr_idx [NRET];
    logic [OCC_W-1:0]  free_cnt;
    logic              push_ok, push_drop, pop;
    logic [4:0]        cmp_mask;

    // Compact valid channels into consecutive slots starting at the write pointer
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < NRET; i++) begin
            wr_idx[i] = wr_ptr_q + push_cnt[PTR_W-1:0];
            if (dut_valid_i[i]) push_cnt = push_cnt + OCC_W'(1);
        end
    end

    // A push is all-or-nothing against the pre-pop free space; flush discards it
    assign free_cnt  = DEPTH_OCC - occ_q;
    assign push_ok   = !flush_i && (push_cnt != '0) && (push_cnt <= free_cnt);
    assign push_drop = !flush_i && (push_cnt > free_cnt);

    assign ref_ready_o = (occ_q != '0) && (state_q == ST_RUN);
    assign pop         = ref_valid_i && ref_ready_o && !flush_i;

    // Field comparison of the head entry; write data only matters when rd != x0
    always_comb begin
        cmp_mask    = '0;
        cmp_mask[0] = (q_order[rd_ptr_q] != ref_order_i) || (q_pc[rd_ptr_q] != ref_pc_i);
        cmp_mask[1] = (q_insn[rd_ptr_q] != ref_insn_i);
        cmp_mask[2] = (q_trap[rd_ptr_q] != ref_trap_i);
        cmp_mask[3] = (q_rd[rd_ptr_q] != ref_rd_addr_i);
        cmp_mask[4] = (q_rd[rd_ptr_q] != 5'd0) && (q_wdata[rd_ptr_q] != ref_rd_wdata_i);
    end

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + push_cnt[PTR_W-1:0];
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            occ_d = occ_q + (push_ok ? push_cnt : '0) - OCC_W'(pop);
        end
    end

    // Entry write port; contents need no reset since occupancy gates their use
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            for (int i = 0; i < NRET; i++) begin
                if (dut_valid_i[i]) begin
                    q_order[wr_idx[i]] <= dut_order_i[i*64 +: 64];
                    q_pc[wr_idx[i]]    <= dut_pc_i[i*XLEN +: XLEN];
                    q_insn[wr_idx[i]]  <= dut_insn_i[i*32 +: 32];
                    q_trap[wr_idx[i]]  <= dut_trap_i[i];
                    q_rd[wr_idx[i]]    <= dut_rd_addr_i[i*5 +: 5];
                    q_wdata[wr_idx[i]] <= dut_rd_wdata_i[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Control state, RUN/HALT FSM and registered comparison results
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            cmp_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            mask_q      <= '0;
            mm_cnt_q    <= '0;
            first_mm_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            cmp_valid_q <= pop;
            mismatch_q  <= pop && (cmp_mask != '0);
            mask_q      <= pop ? cmp_mask : 5'd0;
            if (push_drop) overflow_q <= 1'b1;
            if (pop && (cmp_mask != '0)) begin
                if (mm_cnt_q != 16'hFFFF) mm_cnt_q <= mm_cnt_q + 16'd1;
                if (mm_cnt_q == 16'd0)    first_mm_q <= q_order[rd_ptr_q];
            end
            case (state_q)
                ST_RUN: begin
                    if (!flush_i && pop && (cmp_mask != '0) && (STOP_ON_MISMATCH != 0))
                        state_q <= ST_HALT;
                end
                ST_HALT: begin
                    if (flush_i) state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign cmp_valid_o      = cmp_valid_q;
    assign mismatch_o       = mismatch_q;
    assign mismatch_mask_o  = mask_q;
    assign mismatch_cnt_o   = mm_cnt_q;
    assign first_mm_order_o = first_mm_q;
    assign overflow_o       = overflow_q;
    assign halted_o         = (state_q == ST_HALT);
    assign occupancy_o      = occ_q;

endmodule

// File: doc/rvfi_compare_queue.md
RVFI_COMPARE_QUEUE -- requirements
Module: rvfi_compare_queue

Interface
REQ-001 SHALL have parameter NRET, default 2, number of DUT retirement channels (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, queue entries (power of 2, >= 2*NRET).
REQ-003 SHALL have parameter XLEN, default 32, data/PC width (32 or 64).
REQ-004 SHALL have parameter STOP_ON_MISMATCH, default 1, halt reference consumption after the first mismatch.
REQ-005 SHALL have one clock and an asynchronous, active-low reset:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have these DUT ports:
- dut_valid_i  in  NRET  per-channel retire valid.
- dut_order_i  in  NRET*64  instruction order.
- dut_pc_i  in  NRET*XLEN  PC.
- dut_insn_i  in  NRET*32  instruction word.
- dut_trap_i  in  NRET  trap flag.
- dut_rd_addr_i  in  NRET*5  destination register.
- dut_rd_wdata_i  in  NRET*XLEN  write data.
REQ-007 SHALL have these reference-model ports:
- ref_valid_i  in  1  reference retirement valid.
- ref_ready_o  out  1  queue accepts a comparison.
- ref_order_i, ref_pc_i, ref_insn_i, ref_trap_i, ref_rd_addr_i, ref_rd_wdata_i  in  widths as DUT  reference fields.
REQ-008 SHALL have these control and status ports:
- flush_i  in  1  synchronous flush.
- cmp_valid_o  out  1  comparison result valid.
- mismatch_o  out  1  result is a mismatch.
- mismatch_mask_o  out  5  {rd_wdata, rd_addr, trap, insn, pc|order}.
- mismatch_cnt_o  out  16  saturating mismatch count.
- first_mm_order_o  out  64  order of the first mismatch.
- overflow_o  out  1  sticky overflow.
- halted_o  out  1  in HALT state.
- occupancy_o  out  $clog2(DEPTH)+1  entries held.

Function
REQ-009 SHALL push valid DUT channels each cycle in ascending channel index order, compacted into consecutive entries, regardless of gaps in dut_valid_i.
REQ-010 SHALL accept a push only if free entries >= popcount(dut_valid_i).
- Otherwise SHALL drop all of that cycle's entries and set overflow_o (sticky until reset).
REQ-011 SHALL drive ref_ready_o = (registered occupancy != 0) && state == RUN.
- An entry pushed in cycle N SHALL be poppable no earlier than cycle N+1.
REQ-012 SHALL pop the head entry on ref_valid_i && ref_ready_o and compare it with the ref fields.
REQ-013 SHALL compare fields as follows:
- pc and order: one mask bit, set if either differs.
- insn and trap: one mask bit each.
- rd_addr: one mask bit.
- rd_wdata: compared only when the DUT rd_addr != 0.
REQ-014 SHALL register the comparison result: cmp_valid_o, mismatch_o and mismatch_mask_o are valid in the cycle after the handshake and are single-cycle pulses.
- When cmp_valid_o is 0, mismatch_o and mismatch_mask_o SHALL be 0.
REQ-015 SHALL, on each mismatch, increment mismatch_cnt_o, saturating at 16'hFFFF.
- On the first mismatch since reset, SHALL capture the DUT order into first_mm_order_o; later mismatches SHALL NOT change it.
REQ-016 SHALL give a push and a pop in the same cycle both effect: occupancy_next = occupancy + pushes - pop.
- Free-space evaluation for the push SHALL use the pre-pop occupancy.
REQ-017 SHALL wrap read and write pointers modulo DEPTH.
- Full and empty SHALL be distinguished by occupancy, not by pointer equality.
REQ-018 SHALL implement a state machine with states RUN and HALT.
- RUN -> HALT: on a mismatch when STOP_ON_MISMATCH=1, in the cycle mismatch_o is asserted.
- HALT -> RUN: only on flush_i.
- With STOP_ON_MISMATCH=0, the block SHALL never leave RUN.
REQ-019 SHALL, on flush_i:
- empty the queue (occupancy 0, pointers 0) and enter RUN in the next cycle;
- discard any push or pop in that same cycle;
- leave counters, first_mm_order_o and overflow_o unchanged.
REQ-020 SHALL drive halted_o high exactly while the state is HALT.
- In HALT, DUT pushes SHALL continue, subject to REQ-010.

Reset
REQ-021 SHALL, on assertion of rst_ni low, immediately and asynchronously drive:
- all outputs to 0 and the state to RUN;
- occupancy and pointers to 0, first_mm_order_o to 0, overflow_o to 0.
REQ-022 SHALL, when reset asserts mid-operation, discard queued entries and any pending comparison result.
REQ-023 SHALL resume normal operation on the first rising edge after rst_ni deasserts.

Verification
REQ-024 NRET=2: push two channels with orders 5 and 6 in one cycle; then drive ref orders 5 and 6 with matching fields -> two cmp_valid_o pulses, mismatch_o=0, occupancy returns to 0.
REQ-025 dut_valid_i=2'b10 with order 9 -> the entry is stored at the head; ref order 9 with pc differing -> mismatch_mask_o=5'b00001, mismatch_cnt_o=1, first_mm_order_o=9, halted_o=1, ref_ready_o=0.
REQ-026 DEPTH=8 holding 7 entries, NRET=2 push of two entries with no pop -> both dropped, overflow_o=1, occupancy_o stays 7; the same push with a simultaneous pop -> both dropped (pre-pop occupancy is used).
REQ-027 ref entry with rd_addr=0 and rd_wdata differing -> mismatch_o=0; the same with rd_addr=3 -> mask bit 4 set.
REQ-028 In HALT with 3 queued entries, flush_i=1 -> occupancy_o=0 and halted_o=0 next cycle, mismatch_cnt_o unchanged; then push 17 entries over time, wrapping the pointers twice -> all compare with no mismatch.
REQ-029 rst_ni low while 4 entries are queued and a comparison is in flight -> all outputs 0 immediately and no cmp_valid_o pulse after reset release.
